// File: rtl/imem_loader.sv
// Program loader: receives a framed byte stream, writes 32-bit words into the
// instruction RAM and holds the CPU while a frame is in progress.
module imem_loader #(
  parameter int         MAX_WORDS = 256,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [30:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t             r_state, w_state_nx;
  logic               r_wr_en, w_wr_en_nx;
  logic [30:0]        r_wr_addr, w_wr_addr_nx;
  logic [31:0]        r_wr_data, w_wr_data_nx;
  logic               r_cpu_hold, w_cpu_hold_nx;
  logic               r_done, w_done_nx;
  logic               r_error, w_error_nx;
  logic [15:0]        r_words, w_words_nx;
  logic [7:0]         r_chk, w_chk_nx;
  logic [7:0]         r_cnt_hi, w_cnt_hi_nx;
  logic [15:0]        r_n, w_n_nx;
  logic [1:0]         r_bcnt, w_bcnt_nx;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nx;

  logic [15:0]        w_words_inc;
  logic [15:0]        w_n_rx;
  logic               w_in_frame;

  assign w_words_inc = r_words + 16'd1;
  assign w_n_rx      = {r_cnt_hi, rx_data};
  assign w_in_frame  = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                       (r_state == S_DATA)   || (r_state == S_CHECK);

  always_comb begin
    w_state_nx    = r_state;
    w_wr_en_nx    = 1'b0;
    w_wr_addr_nx  = r_wr_addr;
    w_wr_data_nx  = r_wr_data;
    w_cpu_hold_nx = r_cpu_hold;
    w_done_nx     = r_done;
    w_error_nx    = r_error;
    w_words_nx    = r_words;
    w_chk_nx      = r_chk;
    w_cnt_hi_nx   = r_cnt_hi;
    w_n_nx        = r_n;
    w_bcnt_nx     = r_bcnt;
    w_tmo_nx      = '0;

    // Inter-byte watchdog only runs while a frame is open.
    if (w_in_frame && !rx_valid) begin
      if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
        w_state_nx    = S_ERR;
        w_error_nx    = 1'b1;
        w_cpu_hold_nx = 1'b0;
      end else begin
        w_tmo_nx = r_tmo + 1'b1;
      end
    end

    if (rx_valid) begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (rx_data == SYNC_BYTE) begin
            w_state_nx    = S_CNT_HI;
            w_cpu_hold_nx = 1'b1;
            w_done_nx     = 1'b0;
            w_error_nx    = 1'b0;
            w_words_nx    = '0;
            w_chk_nx      = '0;
            w_bcnt_nx     = '0;
          end
        end
        S_CNT_HI: begin
          w_cnt_hi_nx = rx_data;
          w_chk_nx    = r_chk ^ rx_data;
          w_state_nx  = S_CNT_LO;
        end
        S_CNT_LO: begin
          w_n_nx   = w_n_rx;
          w_chk_nx = r_chk ^ rx_data;
          if (w_n_rx > 16'(MAX_WORDS)) begin
            w_state_nx    = S_ERR;
            w_error_nx    = 1'b1;
            w_cpu_hold_nx = 1'b0;
          end else if (w_n_rx == 16'd0) begin
            w_state_nx = S_CHECK;
          end else begin
            w_state_nx = S_DATA;
          end
        end
        S_DATA: begin
          w_wr_data_nx = {r_wr_data[23:0], rx_data};
          w_chk_nx     = r_chk ^ rx_data;
          w_bcnt_nx    = r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            w_wr_en_nx   = 1'b1;
            w_wr_addr_nx = {13'd0, r_words, 2'b00};
            w_words_nx   = w_words_inc;
            if (w_words_inc == r_n) begin
              w_state_nx = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          w_cpu_hold_nx = 1'b0;
          if (rx_data == r_chk) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
          end else begin
            w_state_nx = S_ERR;
            w_error_nx = 1'b1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_words    <= '0;
      r_chk      <= '0;
      r_cnt_hi   <= '0;
      r_n        <= '0;
      r_bcnt     <= '0;
      r_tmo      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_wr_en    <= w_wr_en_nx;
      r_wr_addr  <= w_wr_addr_nx;
      r_wr_data  <= w_wr_data_nx;
      r_cpu_hold <= w_cpu_hold_nx;
      r_done     <= w_done_nx;
      r_error    <= w_error_nx;
      r_words    <= w_words_nx;
      r_chk      <= w_chk_nx;
      r_cnt_hi   <= w_cnt_hi_nx;
      r_n        <= w_n_nx;
      r_bcnt     <= w_bcnt_nx;
      r_tmo      <= w_tmo_nx;
    end
  end

  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign cpu_hold     = r_cpu_hold;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed frame table, hand-written corner sequences and
// random frames checked against a frame-level reference model.
module tb_imem_loader;

  localparam int TMO  = 200;
  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [30:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.MAX_WORDS(MAXW), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [62:0] wq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Capture every RAM write; words_loaded must already count the word being written.
  always @(negedge clk) begin
    if (reset === 1'b1 && wr_en === 1'b1) begin
      wq.push_back({wr_addr, wr_data});
      chk("wr_hold", 64'(cpu_hold), 64'd1);
      chk("wr_words", 64'(words_loaded), 64'(wr_addr >> 2) + 64'd1);
    end
  end

  task automatic send(input logic [7:0] q[$], input int gap);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rx_data  = q[i];
      rx_valid = 1'b1;
      if (gap > 0) begin
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    if (gap == 0) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Frame-level model: parse count, slice words, XOR checksum.
  task automatic model(input logic [7:0] q[$], output logic [62:0] ew[$],
                       output bit d, output bit e, output int w);
    int n;
    logic [7:0] c;
    ew = {};
    d = 1'b0; e = 1'b0; w = 0;
    n = {16'd0, q[1], q[2]};
    if (n > MAXW) begin
      e = 1'b1;
      return;
    end
    c = q[1] ^ q[2];
    for (int k = 0; k < n; k++) begin
      ew.push_back({31'(4 * k), q[3+4*k], q[4+4*k], q[5+4*k], q[6+4*k]});
      c = c ^ q[3+4*k] ^ q[4+4*k] ^ q[5+4*k] ^ q[6+4*k];
      w = k + 1;
    end
    if (q[3+4*n] == c) d = 1'b1;
    else e = 1'b1;
  endtask

  task automatic run_frame(input string nm, input logic [7:0] q[$], input int gap,
                           input bit ed, input bit ee, input int ewords);
    logic [62:0] ew[$];
    bit md, me;
    int mw;
    model(q, ew, md, me, mw);
    wq.delete();
    send(q, gap);
    repeat (2) @(negedge clk);
    chk({nm, "_done"}, 64'(done), 64'(ed));
    chk({nm, "_error"}, 64'(error), 64'(ee));
    chk({nm, "_hold"}, 64'(cpu_hold), 64'd0);
    chk({nm, "_words"}, 64'(words_loaded), 64'(ewords));
    chk({nm, "_nwr"}, 64'(wq.size()), 64'(ew.size()));
    for (int i = 0; i < ew.size() && i < wq.size(); i++)
      chk({nm, "_wr"}, 64'(wq[i]), 64'(ew[i]));
  endtask

  typedef struct {
    logic [127:0] bytes;
    int           len;
    int           gap;
    bit           e_done;
    bit           e_err;
    int           e_words;
  } vec_t;

  vec_t vt[7];

  function automatic void to_q(input logic [127:0] b, input int len, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < len; i++) q.push_back(b[127-8*i -: 8]);
  endfunction

  initial begin : main
    logic [7:0] q[$];
    logic [62:0] ew[$];
    bit md, me;
    int mw, n, gap, nj;
    logic [7:0] c, jb;

    vt[0] = '{128'hA5000208_00000308_00002B2A_00000000, 12, 0, 1'b1, 1'b0, 2};
    vt[1] = '{128'hA5000208_00000308_00002B2A_00000000, 12, 1, 1'b1, 1'b0, 2};
    vt[2] = '{128'hA5000208_00000308_00002B2B_00000000, 12, 0, 1'b0, 1'b1, 2};
    vt[3] = '{128'hA50101_00_00000000_00000000_00000000, 3, 0, 1'b0, 1'b1, 0};
    vt[4] = '{128'hA5000000_00000000_00000000_00000000, 4, 0, 1'b1, 1'b0, 0};
    vt[5] = '{128'hA5000001_00000000_00000000_00000000, 4, 2, 1'b0, 1'b1, 0};
    vt[6] = '{128'hA5000208_00000308_00002B2A_00000000, 12, 2, 1'b1, 1'b0, 2};

    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_outs", {wr_en, wr_addr, cpu_hold, done, error, words_loaded, 13'd0}, 64'd0);
    chk("rst_data", 64'(wr_data), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // T1 by hand: hold rises on sync, writes land at fixed addresses.
    to_q(vt[0].bytes, 12, q);
    wq.delete();
    send(q[0:0], 0);
    chk("t1_hold_on", 64'(cpu_hold), 64'd1);
    send(q[1:11], 0);
    repeat (2) @(negedge clk);
    chk("t1_nwr", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk("t1_w0", 64'(wq[0]), 64'({31'd0, 32'h08000003}));
      chk("t1_w1", 64'(wq[1]), 64'({31'd4, 32'h0800002B}));
    end
    chk("t1_done", 64'({done, error, cpu_hold}), 64'b100);

    for (int i = 0; i < 7; i++) begin
      to_q(vt[i].bytes, vt[i].len, q);
      run_frame($sformatf("vec%0d", i), q, vt[i].gap, vt[i].e_done, vt[i].e_err, vt[i].e_words);
    end

    // T5: inter-byte timeout inside the data phase.
    wq.delete();
    to_q(128'hA5000112_34000000_00000000_00000000, 5, q);
    send(q, 0);
    repeat (TMO - 10) @(negedge clk);
    chk("t5_pre", 64'({error, cpu_hold}), 64'b01);
    repeat (15) @(negedge clk);
    chk("t5_post", 64'({done, error, cpu_hold}), 64'b010);
    chk("t5_nwr", 64'(wq.size()), 64'd0);

    // T6: asynchronous reset after the third data byte, then a clean reload.
    wq.delete();
    to_q(128'hA5000208_0000_0000_00000000_00000000, 6, q);
    send(q, 0);
    #2 reset = 1'b0;
    #1 chk("t6_rst", {wr_en, wr_addr, cpu_hold, done, error, words_loaded, 13'd0}, 64'd0);
    chk("t6_rst_data", 64'(wr_data), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_nwr", 64'(wq.size()), 64'd0);
    to_q(vt[0].bytes, 12, q);
    run_frame("t6_reload", q, 0, 1'b1, 1'b0, 2);

    // Random frames with idle junk, random gaps, bad checksums and oversize counts.
    for (int f = 0; f < 40; f++) begin
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h5A;
        send('{jb}, 0);
      end
      if ($urandom_range(0, 9) == 0) n = MAXW + 1 + $urandom_range(0, 50);
      else n = $urandom_range(0, 5);
      q = '{8'hA5, n[15:8], n[7:0]};
      if (n <= MAXW) begin
        c = n[15:8] ^ n[7:0];
        for (int k = 0; k < 4 * n; k++) begin
          q.push_back(8'($urandom));
          c = c ^ q[q.size() - 1];
        end
        if ($urandom_range(0, 3) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
        q.push_back(c);
      end
      gap = $urandom_range(0, 2);
      model(q, ew, md, me, mw);
      run_frame($sformatf("rnd%0d", f), q, gap, md, me, mw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
